uart_cfg_core: RTL and testbench

Next-generation UART core for the RISC-V SoC peripheral bus. It is runtime-configurable, where the current UART fixes its framing at build time. Settings covered: baud divisor, 7/8 data bits, parity (none/even/odd), 1 or 2 stop bits. The block contains a tick generator, 16x-oversampled RX and TX FSMs, one RX FIFO and one TX FIFO, sticky error flags and FIFO fill levels. It sits between the bus-side register file and the rx/tx pins.

---
 rtl/uart_cfg_core.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
// Runtime-configurable UART: baud tick generator, 16x-oversampled RX/TX FSMs,
// show-ahead RX/TX FIFOs, sticky error flags and FIFO fill levels.

module uart_cfg_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [7:0]       w_data,
  input  logic             rd,
  output logic [7:0]       r_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             wr_en, rd_en;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level  = wr_ptr_reg - rd_ptr_reg;
  assign empty  = (level == '0);
  assign full   = (level == LVL_W'(DEPTH));
  assign rd_en  = rd && !empty;
  assign wr_en  = wr && (!full || rd);
  assign r_data = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + LVL_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + LVL_W'(1);
    end
  end
endmodule

module uart_cfg_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int DVSR_W     = 11,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              cfg_dbit8,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              rx,
  input  logic              rd_uart,
  output logic [7:0]        r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [LVL_W-1:0]  rx_level,
  input  logic              wr_uart,
  input  logic [7:0]        w_data,
  output logic              tx,
  output logic              tx_full,
  output logic [LVL_W-1:0]  tx_level,
  output logic              tx_busy,
  input  logic              clr_err,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [DVSR_W-1:0] tick_cnt_reg;
  logic              tick;

  assign tick = (tick_cnt_reg >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + DVSR_W'(1);
  end

  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // ---------------- receiver ----------------
  state_t     rx_state_reg;
  logic [3:0] rx_s_reg;
  logic [2:0] rx_n_reg;
  logic [7:0] rx_b_reg;
  logic       rx_dbit8_reg, rx_par_en_reg, rx_par_odd_reg, rx_stop2_reg;
  logic       rx_push_reg, perr_set_reg, ferr_set_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg   <= ST_IDLE;
      rx_s_reg       <= '0;
      rx_n_reg       <= '0;
      rx_b_reg       <= '0;
      rx_dbit8_reg   <= 1'b1;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
      rx_stop2_reg   <= 1'b0;
      rx_push_reg    <= 1'b0;
      perr_set_reg   <= 1'b0;
      ferr_set_reg   <= 1'b0;
    end else begin
      rx_push_reg  <= 1'b0;
      perr_set_reg <= 1'b0;
      ferr_set_reg <= 1'b0;
      case (rx_state_reg)
        ST_IDLE: begin
          if (!rx_sync_reg) begin
            rx_state_reg   <= ST_START;
            rx_s_reg       <= '0;
            rx_b_reg       <= '0;
            rx_dbit8_reg   <= cfg_dbit8;
            rx_par_en_reg  <= cfg_parity[0] ^ cfg_parity[1];
            rx_par_odd_reg <= cfg_parity[1];
            rx_stop2_reg   <= cfg_stop2;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s_reg == 4'd7) begin
              // Mid start bit: a high line here was only a glitch.
              rx_s_reg     <= '0;
              rx_n_reg     <= '0;
              rx_state_reg <= rx_sync_reg ? ST_IDLE : ST_DATA;
            end else begin
              rx_s_reg <= rx_s_reg + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rx_s_reg <= rx_s_reg + 4'd1;
            if (rx_s_reg == 4'd15) begin
              rx_b_reg[rx_n_reg] <= rx_sync_reg;
              if (rx_n_reg == {2'b11, rx_dbit8_reg}) begin
                rx_n_reg     <= '0;
                rx_state_reg <= rx_par_en_reg ? ST_PARITY : ST_STOP;
              end else begin
                rx_n_reg <= rx_n_reg + 3'd1;
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            rx_s_reg <= rx_s_reg + 4'd1;
            if (rx_s_reg == 4'd15) begin
              perr_set_reg <= ((^rx_b_reg) ^ rx_sync_reg) != rx_par_odd_reg;
              rx_state_reg <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            rx_s_reg <= rx_s_reg + 4'd1;
            if (rx_s_reg == 4'd15) begin
              if (!rx_sync_reg) ferr_set_reg <= 1'b1;
              if (rx_n_reg[0] == rx_stop2_reg) begin
                rx_push_reg  <= 1'b1;
                rx_state_reg <= ST_IDLE;
              end else begin
                rx_n_reg <= 3'd1;
              end
            end
          end
        end
        default: rx_state_reg <= ST_IDLE;
      endcase
    end
  end

  uart_cfg_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_push_reg),
    .w_data (rx_b_reg),
    .rd     (rd_uart),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full),
    .level  (rx_level)
  );

  logic parity_err_reg, frame_err_reg, overrun_err_reg;

  // Set is applied after clear so a same-cycle event keeps the flag high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      if (clr_err) begin
        parity_err_reg  <= 1'b0;
        frame_err_reg   <= 1'b0;
        overrun_err_reg <= 1'b0;
      end
      if (perr_set_reg) parity_err_reg <= 1'b1;
      if (ferr_set_reg) frame_err_reg  <= 1'b1;
      if (rx_push_reg && rx_full && !rd_uart) overrun_err_reg <= 1'b1;
    end
  end

  assign parity_err  = parity_err_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;

  // ---------------- transmitter ----------------
  state_t     tx_state_reg;
  logic [3:0] tx_s_reg;
  logic [2:0] tx_n_reg;
  logic [7:0] tx_b_reg;
  logic       tx_dbit8_reg, tx_par_en_reg, tx_pbit_reg, tx_stop2_reg;
  logic       tx_reg, tx_busy_reg;
  logic [7:0] tx_head;
  logic       tx_empty, tx_pop;

  assign tx_pop = (tx_state_reg == ST_IDLE) && !tx_empty;

  uart_cfg_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_uart),
    .w_data (w_data),
    .rd     (tx_pop),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full),
    .level  (tx_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg  <= ST_IDLE;
      tx_s_reg      <= '0;
      tx_n_reg      <= '0;
      tx_b_reg      <= '0;
      tx_dbit8_reg  <= 1'b1;
      tx_par_en_reg <= 1'b0;
      tx_pbit_reg   <= 1'b0;
      tx_stop2_reg  <= 1'b0;
      tx_reg        <= 1'b1;
      tx_busy_reg   <= 1'b0;
    end else begin
      case (tx_state_reg)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_b_reg      <= tx_head;
            tx_dbit8_reg  <= cfg_dbit8;
            tx_par_en_reg <= cfg_parity[0] ^ cfg_parity[1];
            // Parity bit that makes data^parity equal 0 (even) or 1 (odd).
            tx_pbit_reg   <= (^(cfg_dbit8 ? tx_head : {1'b0, tx_head[6:0]})) ^ cfg_parity[1];
            tx_stop2_reg  <= cfg_stop2;
            tx_busy_reg   <= 1'b1;
            tx_s_reg      <= '0;
            tx_reg        <= 1'b0;
            tx_state_reg  <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_s_reg <= tx_s_reg + 4'd1;
            if (tx_s_reg == 4'd15) begin
              tx_reg       <= tx_b_reg[0];
              tx_n_reg     <= '0;
              tx_state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tx_s_reg <= tx_s_reg + 4'd1;
            if (tx_s_reg == 4'd15) begin
              tx_b_reg <= {1'b0, tx_b_reg[7:1]};
              if (tx_n_reg == {2'b11, tx_dbit8_reg}) begin
                tx_n_reg     <= '0;
                tx_reg       <= tx_par_en_reg ? tx_pbit_reg : 1'b1;
                tx_state_reg <= tx_par_en_reg ? ST_PARITY : ST_STOP;
              end else begin
                tx_n_reg <= tx_n_reg + 3'd1;
                tx_reg   <= tx_b_reg[1];
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx_s_reg <= tx_s_reg + 4'd1;
            if (tx_s_reg == 4'd15) begin
              tx_reg       <= 1'b1;
              tx_n_reg     <= '0;
              tx_state_reg <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tx_s_reg <= tx_s_reg + 4'd1;
            if (tx_s_reg == 4'd15) begin
              if (tx_n_reg[0] == tx_stop2_reg) begin
                tx_busy_reg  <= 1'b0;
                tx_state_reg <= ST_IDLE;
              end else begin
                tx_n_reg <= 3'd1;
              end
            end
          end
        end
        default: tx_state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = tx_busy_reg;
endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed-plus-random bench for uart_cfg_core; frames are predicted from the
// UART framing rules and received bytes from a queue model of the RX FIFO.

module tb_uart_cfg_core;
  localparam int DEPTH  = 4;
  localparam int DVSR_W = 11;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DVSR_W-1:0] dvsr;
  logic              cfg_dbit8, cfg_stop2;
  logic [1:0]        cfg_parity;
  logic              rx_drv, loop_en, rx_pin;
  logic              rd_uart, wr_uart, clr_err;
  logic [7:0]        w_data, r_data;
  logic              rx_empty, rx_full, tx, tx_full, tx_busy;
  logic [LVL_W-1:0]  rx_level, tx_level;
  logic              parity_err, frame_err, overrun_err;

  int n_cmp = 0;
  int n_bad = 0;
  int bitc;
  logic [7:0] rx_q[$];
  logic       exp_ovr;

  logic [15:0] ef;
  int          elen;
  logic [7:0]  d;
  logic        b8, s2;
  logic [1:0]  par;
  logic [7:0]  txb[6];

  assign rx_pin = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg_core #(.FIFO_DEPTH(DEPTH), .DVSR_W(DVSR_W), .LVL_W(LVL_W)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr),
    .cfg_dbit8(cfg_dbit8), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx(rx_pin), .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_level(rx_level), .wr_uart(wr_uart), .w_data(w_data),
    .tx(tx), .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy),
    .clr_err(clr_err), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Frame as a bit list: start 0, data LSB first, optional parity, stop 1s.
  function automatic void model_frame(input logic [7:0] db, input logic m8, input logic [1:0] mp,
                                      input logic ms2, output logic [15:0] f, output int len);
    int nb;
    int ones;
    nb   = m8 ? 8 : 7;
    ones = 0;
    f    = '1;
    f[0] = 1'b0;
    len  = 1;
    for (int i = 0; i < nb; i++) begin
      f[len[3:0]] = db[i[2:0]];
      ones += int'(db[i[2:0]]);
      len++;
    end
    if (mp == 2'd1) begin
      f[len[3:0]] = (ones % 2 == 1);
      len++;
    end else if (mp == 2'd2) begin
      f[len[3:0]] = (ones % 2 == 0);
      len++;
    end
    len += ms2 ? 2 : 1;
  endfunction

  task automatic set_dvsr(input int v);
    dvsr = DVSR_W'(v);
    bitc = 16 * (v + 1);
  endtask

  task automatic set_cfg(input logic m8, input logic [1:0] mp, input logic ms2);
    cfg_dbit8  = m8;
    cfg_parity = mp;
    cfg_stop2  = ms2;
  endtask

  task automatic write_tx(input logic [7:0] b);
    w_data  = b;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  // Waits for the start bit, samples each bit mid-period and checks frame length.
  task automatic check_tx_frame(input string tag, input logic [15:0] xf, input int xlen,
                                input int pre, input int max_wait);
    int waited;
    int dur;
    logic [15:0] got;
    logic busy_ok;
    waited  = 0;
    got     = '1;
    busy_ok = 1'b1;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, 32'(tx === 1'b0 && waited <= max_wait), 32'(1));
    if (tx === 1'b0) begin
      dur = pre;
      repeat (bitc / 2 - pre) @(negedge clk);
      dur += bitc / 2 - pre;
      for (int i = 0; i < xlen; i++) begin
        if (i > 0) begin
          repeat (bitc) @(negedge clk);
          dur += bitc;
        end
        got[i[3:0]] = tx;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
      end
      check({tag, "_bits"}, 32'(got), 32'(xf));
      check({tag, "_busy"}, 32'(busy_ok), 32'(1));
      while (tx_busy === 1'b1 && dur < xlen * bitc + 50) begin
        @(negedge clk);
        dur++;
      end
      $display("tx %s: frame %b len %0d, %0d clk", tag, got, xlen, dur);
      check({tag, "_len"}, 32'(dur >= xlen * bitc - (bitc / 16 - 1) && dur <= xlen * bitc), 32'(1));
    end
  endtask

  task automatic drive_rx_frame(input logic [15:0] f, input int len, input logic short_last);
    for (int i = 0; i < len; i++) begin
      rx_drv = f[i[3:0]];
      if (i == len - 1 && short_last) begin
        repeat (bitc * 3 / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bitc / 4) @(negedge clk);
      end else begin
        repeat (bitc) @(negedge clk);
      end
    end
    rx_drv = 1'b1;
    repeat (bitc) @(negedge clk);
  endtask

  task automatic expect_rx(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    $display("rx %s: r_data %02h expected %02h", tag, r_data, e);
    check({tag, "_nonempty"}, 32'(rx_empty), 32'(0));
    check({tag, "_data"}, 32'(r_data), 32'(e));
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    set_dvsr(3);
    set_cfg(1'b1, 2'd0, 1'b0);
    rx_drv = 1'b1; loop_en = 1'b0; rd_uart = 1'b0; wr_uart = 1'b0;
    clr_err = 1'b0; w_data = 8'h00; exp_ovr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(tx_busy), 32'(0));
    check("rst_rx_empty", 32'(rx_empty), 32'(1));
    check("rst_r_data", 32'(r_data), 32'(0));
    check("rst_levels", 32'({rx_level, tx_level}), 32'(0));
    check("rst_full", 32'({rx_full, tx_full}), 32'(0));
    check("rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: level goes 1 -> 0 as the frame starts
    write_tx(8'hA5);
    check("a5_level1", 32'(tx_level), 32'(1));
    @(negedge clk);
    check("a5_level0", 32'(tx_level), 32'(0));
    check("a5_busy", 32'(tx_busy), 32'(1));
    model_frame(8'hA5, 1'b1, 2'd0, 1'b0, ef, elen);
    check_tx_frame("a5", ef, elen, 0, 400);
    repeat (10) @(negedge clk);

    // 7E2 0x55 looped back to RX
    loop_en = 1'b1;
    set_cfg(1'b0, 2'd1, 1'b1);
    write_tx(8'h55);
    model_frame(8'h55, 1'b0, 2'd1, 1'b1, ef, elen);
    check_tx_frame("lb55", ef, elen, 0, 400);
    repeat (10) @(negedge clk);
    expect_rx(8'h55);
    pop_check("lb55");
    check("lb55_flags", 32'({parity_err, frame_err, overrun_err}), 32'(0));

    // Random loopback frames; config changes mid-frame must not disturb them
    for (int k = 0; k < 8; k++) begin
      set_dvsr(int'($urandom_range(0, 3)));
      d = 8'($urandom); b8 = 1'($urandom); par = 2'($urandom); s2 = 1'($urandom);
      set_cfg(b8, par, s2);
      model_frame(d, b8, par, s2, ef, elen);
      write_tx(d);
      fork
        check_tx_frame("lb_rand", ef, elen, 0, 400);
        begin
          repeat (20) @(negedge clk);
          set_cfg(1'($urandom), 2'($urandom), 1'($urandom));
        end
      join
      repeat (10) @(negedge clk);
      expect_rx(b8 ? d : {1'b0, d[6:0]});
      pop_check("lb_rand");
      check("lb_rand_flags", 32'({parity_err, frame_err, overrun_err}), 32'(0));
    end
    loop_en = 1'b0;
    set_dvsr(3);

    // 8O1 0x3C with the wrong parity bit
    set_cfg(1'b1, 2'd2, 1'b0);
    model_frame(8'h3C, 1'b1, 2'd2, 1'b0, ef, elen);
    ef[9] = ~ef[9];
    drive_rx_frame(ef, elen, 1'b0);
    expect_rx(8'h3C);
    check("perr_set", 32'({parity_err, frame_err}), 32'(2'b10));
    pop_check("perr");
    pulse_clr();
    check("perr_clr", 32'(parity_err), 32'(0));

    // Stop bit low: frame error, byte still pushed, no phantom byte
    set_cfg(1'b1, 2'd0, 1'b0);
    d = 8'($urandom);
    model_frame(d, 1'b1, 2'd0, 1'b0, ef, elen);
    ef[9] = 1'b0;
    drive_rx_frame(ef, elen, 1'b1);
    repeat (bitc) @(negedge clk);
    expect_rx(d);
    check("ferr_set", 32'({parity_err, frame_err}), 32'(2'b01));
    check("ferr_level", 32'(rx_level), 32'(1));
    pop_check("ferr");
    pulse_clr();
    check("ferr_clr", 32'(frame_err), 32'(0));

    // Three-tick glitch on an idle line
    rx_drv = 1'b0;
    repeat (3 * (bitc / 16)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * bitc) @(negedge clk);
    check("glitch_empty", 32'(rx_empty), 32'(1));
    check("glitch_flags", 32'({parity_err, frame_err, overrun_err}), 32'(0));

    // Five bytes into a four-entry RX FIFO
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      model_frame(d, 1'b1, 2'd0, 1'b0, ef, elen);
      drive_rx_frame(ef, elen, 1'b0);
      expect_rx(d);
    end
    check("ovr_full", 32'(rx_full), 32'(1));
    check("ovr_level", 32'(rx_level), 32'(DEPTH));
    check("ovr_flag", 32'(overrun_err), 32'(exp_ovr));
    for (int k = 0; k < DEPTH; k++) pop_check("ovr_pop");
    check("ovr_drained", 32'(rx_empty), 32'(1));
    pulse_clr();
    check("ovr_clr", 32'(overrun_err), 32'(0));

    // Six back-to-back TX writes: one is taken by the FSM, four fill the FIFO, one drops
    for (int k = 0; k < 6; k++) txb[k] = 8'($urandom);
    wr_uart = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w_data = txb[k];
      @(negedge clk);
    end
    wr_uart = 1'b0;
    check("txovf_full", 32'(tx_full), 32'(1));
    check("txovf_level", 32'(tx_level), 32'(DEPTH));
    for (int k = 0; k < 5; k++) begin
      model_frame(txb[k], 1'b1, 2'd0, 1'b0, ef, elen);
      check_tx_frame("txovf", ef, elen, (k == 0) ? 4 : 0, (k == 0) ? 400 : 1);
    end
    repeat (3 * bitc) @(negedge clk);
    check("txovf_idle", 32'({tx_busy, tx, tx_level}), 32'({1'b0, 1'b1, LVL_W'(0)}));

    // Reset in the middle of a TX data bit, with bytes waiting in both FIFOs
    d = 8'($urandom);
    model_frame(d, 1'b1, 2'd0, 1'b0, ef, elen);
    drive_rx_frame(ef, elen, 1'b0);
    write_tx(8'h33);
    write_tx(8'hCC);
    repeat (2 * bitc + 20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'(1));
    check("mid_rst_busy", 32'(tx_busy), 32'(0));
    check("mid_rst_levels", 32'({rx_level, tx_level}), 32'(0));
    check("mid_rst_rx_empty", 32'(rx_empty), 32'(1));
    rx_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (bitc) @(negedge clk);
    check("post_rst_tx", 32'({tx, tx_busy}), 32'(2'b10));
    write_tx(8'h0F);
    model_frame(8'h0F, 1'b1, 2'd0, 1'b0, ef, elen);
    check_tx_frame("post_rst", ef, elen, 0, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
